uart_byte_tx: RTL and testbench
===============================

UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQUENCY, default 25_000_000, meaning the clk_i frequency in Hz.
REQ-002 The module SHALL have parameter UART_BAUD_RATE, default 57600, meaning the serial bit rate in baud.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, meaning the byte FIFO depth (power of two, >=2).
REQ-004 The module SHALL have port clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 The module SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 The module SHALL have port data_i  input  8  byte to transmit.
REQ-007 The module SHALL have port valid_i  input  1  data_i valid.
REQ-008 The module SHALL have port ready_o  output  1  FIFO can accept a byte.
REQ-009 The module SHALL have port uart_tx_o  output  1  serial line, idle high.
REQ-010 The module SHALL have port busy_o  output  1  frame in progress or FIFO non-empty.
REQ-011 The module SHALL have port fifo_count_o  output  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO.

Function
REQ-012 The bit period DIV SHALL be CLOCK_FREQUENCY/UART_BAUD_RATE with integer truncation, and elaboration SHALL fail if DIV < 2.
REQ-013 A byte SHALL be accepted on a rising edge where valid_i && ready_o, and ready_o SHALL equal (fifo_count_o != FIFO_DEPTH).
REQ-014 Frame format SHALL be 8N1: one start bit (0), data[0] first through data[7], one stop bit (1), each held exactly DIV cycles, so one frame is 10*DIV cycles.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-016 The FSM SHALL leave IDLE on the first edge where the FIFO is non-empty, popping the head byte into a shift register and entering START.
REQ-017 START SHALL go to DATA after DIV cycles; DATA SHALL go to STOP after 8 bit periods, counted by a 3-bit counter; STOP SHALL last DIV cycles.
REQ-018 At the end of STOP, the FSM SHALL pop and go directly to START with zero idle cycles if the FIFO is non-empty, and SHALL go to IDLE otherwise.
REQ-019 uart_tx_o SHALL be driven from a register, so no combinational path exists from any input.
REQ-020 From a handshake into an empty FIFO with the FSM in IDLE, uart_tx_o SHALL be low starting 2 cycles after the handshake edge.
REQ-021 When a push and a pop occur in the same cycle, fifo_count_o SHALL be unchanged and byte order SHALL be preserved.
REQ-022 When the FIFO is full, the module SHALL not accept data (no bypass), even in a cycle where a pop occurs.
REQ-023 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 The baud counter SHALL count 0..DIV-1 and reload at each bit boundary.
REQ-025 busy_o SHALL equal (state != IDLE) || (fifo_count_o != 0).
REQ-026 data_i SHALL be ignored when valid_i is low, and a value of X on data_i SHALL not propagate in that case.

Reset
REQ-027 While rst_ni is low, outputs SHALL be: uart_tx_o=1, ready_o=1, busy_o=0, fifo_count_o=0; the state SHALL be IDLE, all counters 0, and FIFO pointers 0.
REQ-028 Reset asserted mid-frame SHALL drive uart_tx_o high immediately (asynchronously), discard the partial frame and all FIFO contents, and perform no truncated-frame completion.
REQ-029 After reset release, the first frame SHALL start only after a new handshake.

Structure
REQ-030 Package uart_tx_pkg SHALL hold the state enum (IDLE, START, DATA, STOP), the constants UART_DATA_BITS=8 and UART_FRAME_BITS=10, and a function computing DIV from frequency and baud.
REQ-031 The FIFO SHALL be a separate sub-module uart_tx_fifo (sync, push/pop, count, full/empty), and the FSM, baud counter and shift register SHALL reside in uart_byte_tx.

Verification
REQ-032 Use CLOCK_FREQUENCY=1_000_000 and UART_BAUD_RATE=100_000 (DIV=10). Push 0x41 once; uart_tx_o SHALL be low 2 cycles later, then sample mid-bit 0,1,0,0,0,0,0,1,0,1; frame SHALL be 100 cycles; busy_o SHALL drop right after the stop bit.
REQ-033 Push 0x55, 0xAA, 0x0F back-to-back; the bench SHALL see three frames in order with no idle gap, 300 cycles total from the first start edge.
REQ-034 Hold valid_i high with 6 bytes and FIFO_DEPTH=4; ready_o SHALL fall when count=4, rise one cycle after each pop, and all 6 bytes SHALL be sent in order.
REQ-035 Pull rst_ni low at cycle 45 of a frame; uart_tx_o SHALL be 1 immediately and fifo_count_o SHALL be 0; after release with no push, the line SHALL stay high for 200 cycles.
REQ-036 Push on the exact cycle of a pop with count=2; count SHALL stay 2 and the new byte SHALL be transmitted last.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// UART transmit shared definitions: FSM state encoding, frame constants, bit-period helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop

    // Clock cycles per serial bit, truncated.
    function automatic int calc_div(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with push/pop handshakes, occupancy count and full/empty flags.
// Latency: a pushed word is visible at pop_dat_o the cycle after the push edge.
// Backpressure: pushes while full are dropped (no bypass); pops while empty are ignored.
//
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/push_dat_i write side;
//        pop_i/pop_dat_o read side (pop_dat_o is the current head); count_o occupancy;
//        full_o/empty_o status flags.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Full is checked before any same-cycle pop, so a full FIFO never takes a byte.
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem[rd_ptr_q];

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_dat_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-wide UART 8N1 transmitter fed by a small FIFO.
// Latency: line goes low 2 cycles after a handshake into an empty, idle transmitter.
// Backpressure: ready_o drops while the FIFO is full; back-to-back frames have no idle gap.
//
// Ports: clk_i/rst_ni clock and async active-low reset; data_i/valid_i/ready_o byte
//        handshake; uart_tx_o registered serial line (idle high); busy_o frame active or
//        bytes pending; fifo_count_o bytes waiting in the FIFO.
module uart_byte_tx
    import uart_tx_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 25_000_000,
    parameter int UART_BAUD_RATE  = 57600,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          uart_tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int DIV   = calc_div(CLOCK_FREQUENCY, UART_BAUD_RATE);
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("uart_byte_tx: bit period must be at least 2 clock cycles");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_byte_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t  state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;

    logic       fifo_pop;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (valid_i),
        .push_dat_i (data_i),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .count_o    (fifo_count_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign ready_o   = !fifo_full;
    assign busy_o    = (state_q != IDLE) || (fifo_count_o != '0);
    assign uart_tx_o = tx_q;
    assign bit_end   = (baud_cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        tx_d       = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_head;
                    baud_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    // Chain straight into the next start bit when a byte is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the current state; registering it delays every bit
        // by exactly one cycle, so bit widths and gapless chaining are preserved.
        unique case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: directed and random byte streams against a frame-level model.
// Latency: model line level lags the frame position by one cycle.
// Backpressure: driver holds valid_i until the model reports acceptance.
module tb_uart_byte_tx;
    import uart_tx_pkg::*;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int DEPTH  = 4;
    localparam int FRAME  = UART_FRAME_BITS * DIV;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       uart_tx_o;
    logic       busy_o;
    logic [$clog2(DEPTH):0] fifo_count_o;

    int checks = 0;
    int failures = 0;

    uart_byte_tx #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .UART_BAUD_RATE  (BAUD),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .uart_tx_o    (uart_tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    initial forever #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // ---------------- reference model (frame position arithmetic) ----------------
    logic [7:0] mq[$];          // bytes waiting, oldest first
    int         m_pos = -1;     // cycle index within current frame, -1 when no frame
    logic [7:0] m_cur = '0;
    logic       m_tx = 1'b1;
    logic       m_acc = 1'b0;   // byte accepted on the most recent edge

    function automatic logic line_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= UART_DATA_BITS) return b[k-1];
        return 1'b1;
    endfunction

    initial forever begin : model
        int pre;
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni) begin
            mq.delete();
            m_pos = -1;
            m_tx  = 1'b1;
            m_acc = 1'b0;
        end else begin
            pre   = mq.size();
            m_tx  = (m_pos < 0) ? 1'b1 : line_bit(m_cur, m_pos / DIV);
            m_acc = (valid_i === 1'b1) && (pre != DEPTH);
            if (m_pos < 0 || m_pos == FRAME - 1) begin
                if (pre > 0) begin
                    m_cur = mq.pop_front();
                    m_pos = 0;
                end else begin
                    m_pos = -1;
                end
            end else begin
                m_pos++;
            end
            if (m_acc) mq.push_back(data_i);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk_i);
        check_val("cyc_tx",    uart_tx_o,    m_tx);
        check_val("cyc_ready", ready_o,      mq.size() != DEPTH);
        check_val("cyc_busy",  busy_o,       (m_pos >= 0) || (mq.size() != 0));
        check_val("cyc_count", fifo_count_o, mq.size());
    end

    // ---------------- driver / observer tasks (time base: posedge + 1) ----------------
    task automatic push_stream(input logic [7:0] bq[$]);
        int n;
        for (int i = 0; i < bq.size(); i++) begin
            valid_i = 1'b1;
            data_i  = bq[i];
            n = 0;
            do begin
                @(posedge clk_i); #1;
                n++;
            end while (!m_acc && n < 3000);
            if (!m_acc) check_val("push_timeout", 0, 1);
        end
        valid_i = 1'b0;
        data_i  = 'x;
    endtask

    task automatic expect_frames(input logic [7:0] bq[$], input string tag);
        int n = 0;
        logic [7:0] b;
        int k;
        while (uart_tx_o !== 1'b0 && n < 60) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_val({tag, "_start"}, uart_tx_o, 0);
        for (int c = 0; c < bq.size() * FRAME; c++) begin
            if (c % DIV == DIV / 2) begin
                b = bq[c / FRAME];
                k = (c / DIV) % UART_FRAME_BITS;
                check_val({tag, "_bit"}, uart_tx_o, (k == 0) ? 0 : (k == 9) ? 1 : b[k-1]);
            end
            @(posedge clk_i); #1;
        end
        check_val({tag, "_end_tx"},   uart_tx_o, 1);
        check_val({tag, "_end_busy"}, busy_o,    0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_pos >= 0 || mq.size() != 0) && n < 20000) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_val("idle_timeout", (m_pos >= 0 || mq.size() != 0), 0);
        repeat (3) begin @(posedge clk_i); #1; end
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (m_pos != p && n < 2000) begin
            @(posedge clk_i); #1;
            n++;
        end
        check_val("pos_timeout", m_pos, p);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] q[$];
        logic [7:0] b1, b2, b3, b4;
        valid_i = 1'b0;
        data_i  = 'x;

        // Reset state
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_tx",    uart_tx_o,    1);
        check_val("rst_ready", ready_o,      1);
        check_val("rst_busy",  busy_o,       0);
        check_val("rst_count", fifo_count_o, 0);
        rst_ni = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end

        // Single byte 0x41: 2-cycle latency then a 100-cycle frame
        q = '{8'h41};
        push_stream(q);
        @(posedge clk_i); #1;
        check_val("lat_e1", uart_tx_o, 1);
        @(posedge clk_i); #1;
        check_val("lat_e2", uart_tx_o, 0);
        expect_frames(q, "b41");
        wait_idle();

        // Three bytes back-to-back, no gap between frames
        q = '{8'h55, 8'hAA, 8'h0F};
        fork
            push_stream(q);
            expect_frames(q, "b3");
        join
        wait_idle();

        // Six bytes with valid held high: FIFO fills and throttles
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        fork
            push_stream(q);
            expect_frames(q, "s6");
        join
        wait_idle();

        // Push on the same edge as a pop with two bytes queued
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom); b4 = 8'($urandom);
        q = '{b1, b2, b3};
        push_stream(q);
        check_val("pp_pre_count", fifo_count_o, 2);
        wait_pos(FRAME - 1);
        valid_i = 1'b1;
        data_i  = b4;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        data_i  = 'x;
        check_val("pp_count", fifo_count_o, 2);
        q = '{b2, b3, b4};
        expect_frames(q, "pp");
        wait_idle();

        // Reset mid-frame while the line is low
        q = '{8'h00, 8'h5A};
        push_stream(q);
        wait_pos(45);
        check_val("mr_pre_low", uart_tx_o, 0);
        #1 rst_ni = 1'b0;
        #1;
        check_val("mr_tx",    uart_tx_o,    1);
        check_val("mr_count", fifo_count_o, 0);
        check_val("mr_busy",  busy_o,       0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        for (int c = 0; c < 200; c++) begin
            check_val("mr_idle_line", uart_tx_o, 1);
            @(posedge clk_i); #1;
        end

        // Random bytes with random gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 120)) begin @(posedge clk_i); #1; end
            q = '{8'($urandom)};
            push_stream(q);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
